// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Optional feature macro used by the top level: SEQDET_CNT_EN (match counter).
package seq_det_pkg;

  // Detector FSM: IDLE = no configuration loaded, RUN = detecting.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Overlap-mode encodings for the latched overlap bit.
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Effective pattern length: requested length clamped to the longest supported.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register, fill counter and masked pattern compare.
// hit_o is combinational and is evaluated on the post-shift history, so it
// reflects the bit being accepted on this very cycle.
module seq_det_hist #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,       // cfg_load: wipe history and fill
  input  logic               shift_i,     // accept bit_i this cycle
  input  logic               bit_i,
  input  logic               fill_clr_i,  // non-overlap match: restart fill
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,       // already clamped, 0 = disabled
  output logic               hit_o
);

  logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;

  // Post-shift view of history and fill, plus the low-bit mask for the compare.
  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], bit_i};
    fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    mask       = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (32'(i) < 32'(len_i));
    end
  end

  // Match when enough bits have arrived and the newest len bits equal the pattern.
  always_comb begin
    hit_o = shift_i && (len_i != '0) && (fill_inc >= len_i) &&
            ((hist_shift & mask) == (pattern_i & mask));
  end

  // Next state: stalls hold everything; a non-overlap match restarts the fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (shift_i) begin
      hist_d = hist_shift;
      fill_d = fill_clr_i ? '0 : fill_inc;
    end
  end

  // History and fill registers; reset and reconfiguration both clear them.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime pattern/length and
// overlap / non-overlap mode. Emits a registered one-cycle match pulse.
// Build option SEQDET_CNT_EN: when defined, a saturating CNT_W match counter
// drives match_cnt; otherwise match_cnt is tied to zero.
//
// Handshake: a serial bit is consumed on every rising edge where in_valid is
// high and the block is in RUN with no cfg_load that cycle; there is no
// back-pressure, in_valid low simply freezes all detection state.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q, len_eff;
  logic               overlap_q;
  logic               out_q;
  logic               shift_en, fill_clr, hit;

  // Clamp the requested length and qualify the incoming bit.
  always_comb begin
    len_eff  = LEN_W'(clamp_len(32'(pat_len), MAX_LEN));
    shift_en = in_valid && (state_q == RUN) && !cfg_load;
    fill_clr = hit && (overlap_q == MODE_NONOVL);
  end

  // FSM next state: a load decides RUN vs IDLE from the new length.
  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (len_eff != '0) ? RUN : IDLE;
    end
  end

  // State register and configuration latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= MODE_NONOVL;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        pattern_q <= pattern;
        len_q     <= len_eff;
        overlap_q <= overlap;
      end
    end
  end

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cfg_load),
    .shift_i    (shift_en),
    .bit_i      (in),
    .fill_clr_i (fill_clr),
    .pattern_i  (pattern_q),
    .len_i      (len_q),
    .hit_o      (hit)
  );

  // Registered match pulse, one cycle after the completing bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
    end else begin
      out_q <= hit;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating match counter, cleared by reset and by reconfiguration.
  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule
